// File: rtl/receive_controller_pkg.sv
// receive_controller_pkg: shared constants for the receive dispatch block
package receive_controller_pkg;
   localparam int DEFAULT_COUNT_WIDTH = 16;
endpackage

// File: rtl/types.sv
// types: shared flit definitions for the node receive path
package types;
   typedef struct packed {
      logic       is_ack;
      logic [3:0] src;
      logic [3:0] dst;
      logic [6:0] seq;
   } header_t;
   typedef struct packed {
      header_t     header;
      logic [31:0] payload;
   } flit_t;
endpackage

// File: rtl/receive_controller_sat_counter.sv
// sat_counter: enable-driven up counter that sticks at all-ones, async active-low clear
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (en && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/receive_controller.sv
// receive_controller: steers received flits to ack/packet/waiting-ack buffers and counts traffic
module receive_controller
   import receive_controller_pkg::*;
#(
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  types::flit_t           received_flit,
   input  logic                   received_flit_valid,
   output logic                   received_flit_ready,
   input  logic                   ack_buffer_ready,
   output logic                   ack_buffer_valid,
   input  logic                   packet_buffer_ready,
   output logic                   packet_buffer_valid,
   output logic                   waiting_ack_buffer_valid,
   output logic [COUNT_WIDTH-1:0] data_count,
   output logic [COUNT_WIDTH-1:0] ack_count,
   output logic [COUNT_WIDTH-1:0] stall_count
);
   logic is_ack, data_push, stall;
   always_comb begin
      is_ack                   = received_flit.header.is_ack;
      data_push                = received_flit_valid & ~is_ack & ack_buffer_ready & packet_buffer_ready;
      stall                    = received_flit_valid & ~is_ack & ~(ack_buffer_ready & packet_buffer_ready);
      waiting_ack_buffer_valid = received_flit_valid & is_ack;
      ack_buffer_valid         = data_push;
      packet_buffer_valid      = data_push;
      received_flit_ready      = waiting_ack_buffer_valid | data_push;
   end
   sat_counter #(.W(COUNT_WIDTH)) u_data  (.clk(clk), .rst_n(rst_n), .en(data_push),                .q(data_count));
   sat_counter #(.W(COUNT_WIDTH)) u_ack   (.clk(clk), .rst_n(rst_n), .en(waiting_ack_buffer_valid), .q(ack_count));
   sat_counter #(.W(COUNT_WIDTH)) u_stall (.clk(clk), .rst_n(rst_n), .en(stall),                    .q(stall_count));
endmodule

// File: tb/tb_receive_controller.sv
// tb_receive_controller: directed checks of dispatch handshakes, counters, reset and saturation
module tb_receive_controller;
   logic clk = 0, rst_n = 0;
   types::flit_t flit;
   logic v = 0, ar = 0, pr = 0;
   logic rdy, abv, pbv, wav, rdy_s, abv_s, pbv_s, wav_s;
   logic [15:0] dc, ac, sc;
   logic [1:0]  dc_s, ac_s, sc_s;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   receive_controller dut (
      .clk(clk), .rst_n(rst_n), .received_flit(flit), .received_flit_valid(v),
      .received_flit_ready(rdy), .ack_buffer_ready(ar), .ack_buffer_valid(abv),
      .packet_buffer_ready(pr), .packet_buffer_valid(pbv), .waiting_ack_buffer_valid(wav),
      .data_count(dc), .ack_count(ac), .stall_count(sc));
   receive_controller #(.COUNT_WIDTH(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .received_flit(flit), .received_flit_valid(v),
      .received_flit_ready(rdy_s), .ack_buffer_ready(ar), .ack_buffer_valid(abv_s),
      .packet_buffer_ready(pr), .packet_buffer_valid(pbv_s), .waiting_ack_buffer_valid(wav_s),
      .data_count(dc_s), .ack_count(ac_s), .stall_count(sc_s));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic counts(input string tag, input int d, input int a, input int s, input int d2, input int a2, input int s2);
      chk({tag, ".data"}, 32'(dc), d);
      chk({tag, ".ack"}, 32'(ac), a);
      chk({tag, ".stall"}, 32'(sc), s);
      chk({tag, ".data_s"}, 32'(dc_s), d2);
      chk({tag, ".ack_s"}, 32'(ac_s), a2);
      chk({tag, ".stall_s"}, 32'(sc_s), s2);
   endtask
   task automatic step(input string tag, input logic vv, input logic aa, input logic arr, input logic prr, input logic [3:0] e);
      @(negedge clk);
      v = vv; flit.header.is_ack = aa; ar = arr; pr = prr;
      flit.payload = $urandom;
      #1;
      chk(tag, 32'({rdy, abv, pbv, wav}), 32'(e));
      chk({tag, "_s"}, 32'({rdy_s, abv_s, pbv_s, wav_s}), 32'(e));
      @(posedge clk);
      #1;
   endtask
   initial begin
      flit = '0;
      #12;
      counts("reset", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1;
      step("data_ok", 1, 0, 1, 1, 4'b1110);
      counts("c1", 1, 0, 0, 1, 0, 0);
      step("ack_pr0", 1, 1, 1, 0, 4'b1001);
      counts("c2", 1, 1, 0, 1, 1, 0);
      step("data_ar0", 1, 0, 0, 1, 4'b0000);
      step("data_pr0", 1, 0, 1, 0, 4'b0000);
      counts("c3", 1, 1, 2, 1, 1, 2);
      step("idle_a1", 0, 1, 1, 1, 4'b0000);
      counts("c4", 1, 1, 2, 1, 1, 2);
      step("ack_nordy", 1, 1, 0, 0, 4'b1001);
      step("data_none", 1, 0, 0, 0, 4'b0000);
      step("data_ok2", 1, 0, 1, 1, 4'b1110);
      step("data_ar0b", 1, 0, 0, 1, 4'b0000);
      counts("c5", 2, 2, 4, 2, 2, 3);
      #1;
      rst_n = 0;
      v = 1; flit.header.is_ack = 0; ar = 1; pr = 1;
      #1;
      counts("async_rst", 0, 0, 0, 0, 0, 0);
      chk("hs_in_rst", 32'({rdy, abv, pbv, wav}), 32'(4'b1110));
      @(posedge clk);
      #1;
      counts("rst_hold", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1;
      v = 0;
      for (int i = 0; i < 5; i++) step("ack_burst", 1, 1, i[0], 0, 4'b1001);
      counts("sat", 0, 5, 0, 0, 3, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
